// File: rtl/csa_resolve.sv
// -----------------------------------------------------------------------------
// csa_resolve
//
// Resolves a carry-save pair (s, c) into a binary sum. The value is
// s + 2*c. The carry vector arrives unshifted: c bit i carries weight 2^(i+1).
// The addition is done Chunk bits per cycle, so the wide adder stays a
// Chunk-bit ripple plus a one-bit carry register.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   s/c operand pair is valid
//   in_ready   block can accept an operand pair (high only in IDLE)
//   s          carry-save sum vector, N bits
//   c          carry-save carry vector, N bits, bit i weighted 2^(i+1)
//   out_valid  sum/ovf are valid (high only in DONE)
//   out_ready  downstream accepts the result
//   sum        (s + 2*c) mod 2^N
//   ovf        set when s + 2*c >= 2^N
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer may raise or drop valid at any time, and ready never
// depends on valid. sum/ovf hold steady while out_valid is high and no
// transfer has taken place.
//
// Timing: with the input transfer at edge E, chunks 0..NCHUNK-1 are added on
// edges E+1..E+NCHUNK. Edge E+NCHUNK+1 folds the final carry into ovf and
// enters DONE, so out_valid is high from edge E+1+NCHUNK onward.
// -----------------------------------------------------------------------------
module csa_resolve #(
  parameter int Size     = 3072,
  parameter int Size_bi  = 64,
  parameter int Size_log = 8,
  parameter int Chunk    = 64,
  localparam int N       = Size + Size_bi + Size_log,
  localparam int NCHUNK  = (N + Chunk - 1) / Chunk
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] s,
  input  logic [N-1:0] c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         ovf
);

  // The operand registers are padded to a whole number of chunks. The padding
  // bits are loaded as zero, so the last chunk adds zeros above bit N.
  localparam int NP       = NCHUNK * Chunk;
  localparam int KW       = $clog2(NCHUNK + 1);
  // Position of padded-sum bit N inside the last chunk's (Chunk+1)-bit result.
  localparam int LAST_BIT = N - (NCHUNK - 1) * Chunk;

  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);
  localparam logic [KW-1:0] K_END  = KW'(NCHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [NP-1:0]   a_q;        // captured s, shifted down one chunk per step
  logic [NP-1:0]   b_q;        // captured 2*c (low N bits), shifted likewise
  logic [N-1:0]    sum_q;
  logic            carry_q;
  logic            shout_q;    // c[N-1]: its weight 2^N lies beyond the sum
  logic            ovf_q;
  logic [KW-1:0]   k_q;

  logic [Chunk:0]  chunk_sum;
  logic [31:0]     wr_base;
  logic [N-1:0]    wr_mask;
  logic [N-1:0]    wr_data;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign ovf       = ovf_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)       state_d = ADD;
      ADD:     if (k_q == K_END)   state_d = DONE;
      DONE:    if (out_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Chunk adder: the low chunk of each operand register is always the chunk
  // being worked on, because both registers shift down after every step.
  // ---------------------------------------------------------------------------
  assign chunk_sum = {1'b0, a_q[Chunk-1:0]}
                   + {1'b0, b_q[Chunk-1:0]}
                   + {{Chunk{1'b0}}, carry_q};

  // Only chunk k of sum is rewritten. Shifting the chunk result up into an
  // N-bit field drops any bits at or above N in the last chunk. The higher
  // chunks keep their old contents until the adder reaches them.
  always_comb begin
    wr_base = 32'(k_q) * 32'(Chunk);
    wr_mask = N'({Chunk{1'b1}}) << wr_base;
    wr_data = N'(chunk_sum[Chunk-1:0]) << wr_base;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      shout_q <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= NP'(s);
            b_q     <= NP'({c[N-2:0], 1'b0});
            shout_q <= c[N-1];
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
          end
        end
        ADD: begin
          if (k_q == K_END) begin
            // After the last chunk, carry_q holds padded-sum bit N.
            ovf_q <= carry_q | shout_q;
          end else begin
            sum_q   <= (sum_q & ~wr_mask) | wr_data;
            // The operand bits above N are zero, so in the last chunk the
            // bit at weight 2^N is the overflow. In earlier chunks it is the
            // normal carry out.
            carry_q <= (k_q == K_LAST) ? chunk_sum[LAST_BIT] : chunk_sum[Chunk];
            a_q     <= a_q >> Chunk;
            b_q     <= b_q >> Chunk;
            k_q     <= k_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolve.sv
// -----------------------------------------------------------------------------
// tb_csa_resolve
//
// Bench for csa_resolve at its default parameters. The reference model is
// s + 2*c, computed with plain wide arithmetic. Expected results go into a
// queue when an input transfer happens and come out when an output transfer
// happens.
// -----------------------------------------------------------------------------
module tb_csa_resolve;

  localparam int SIZE     = 3072;
  localparam int SIZE_BI  = 64;
  localparam int SIZE_LOG = 8;
  localparam int CHUNK    = 64;
  localparam int N        = SIZE + SIZE_BI + SIZE_LOG;
  localparam int LAT      = 51;
  localparam int NRAND    = 1000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] s_in;
  logic [N-1:0] c_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum_o;
  logic         ovf_o;

  always #5 clk = ~clk;

  csa_resolve #(
    .Size     (SIZE),
    .Size_bi  (SIZE_BI),
    .Size_log (SIZE_LOG),
    .Chunk    (CHUNK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s_in),
    .c         (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum_o),
    .ovf       (ovf_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [N:0] exp_q[$];   // {ovf, sum}

  // ---------------------------------------------------------------------------
  // Reference model and helpers
  // ---------------------------------------------------------------------------
  function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N+1:0] t;
    t = {2'b00, a} + {1'b0, b, 1'b0};
    return {|t[N+1:N], t[N-1:0]};
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i += 32) v = (v << 32) | N'($urandom);
    return v;
  endfunction

  // Random operand with a bias toward long carry chains and wrap cases.
  function automatic logic [N-1:0] pick_vec();
    logic [N-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '1;
      1:       v = '0;
      2:       begin v = '1; v[$urandom_range(0, N-1)] = 1'b0; end
      default: v = rand_vec();
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  task automatic chk_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got lo64=%h hi64=%h want lo64=%h hi64=%h",
                tag, obs[63:0], obs[N-1:N-64], exp[63:0], exp[N-1:N-64]);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: offer one operand pair and wait for the result.
  // While the block is busy, junk is driven on the inputs.
  // ---------------------------------------------------------------------------
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_sum, input logic exp_ovf, input bit do_release);
    int lat;
    chk_bit({tag, ":in_ready_before"}, in_ready, 1'b1);
    in_valid = 1'b1;
    s_in     = a;
    c_in     = b;
    tick();
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 4 * LAT) begin
      if (lat == 10) chk_bit({tag, ":in_ready_busy"}, in_ready, 1'b0);
      in_valid = 1'($urandom_range(0, 1));
      s_in     = rand_vec();
      c_in     = rand_vec();
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk_int({tag, ":latency"}, lat, LAT);
    chk_vec({tag, ":sum"}, sum_o, exp_sum);
    chk_bit({tag, ":ovf"}, ovf_o, exp_ovf);
    chk_bit({tag, ":in_ready_done"}, in_ready, 1'b0);
    if (do_release) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_bit({tag, ":out_valid_after"}, out_valid, 1'b0);
      chk_bit({tag, ":in_ready_after"}, in_ready, 1'b1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [N-1:0] a, b, e, prev, lowmask;
    logic [N:0]   m;
    int sent, got, cyc;
    logic [N-1:0] cur_s, cur_c;

    in_valid  = 1'b0;
    out_ready = 1'b0;
    s_in      = '0;
    c_in      = '0;
    rst_n     = 1'b0;

    // Reset state
    #2;
    chk_bit("rst:in_ready", in_ready, 1'b1);
    chk_bit("rst:out_valid", out_valid, 1'b0);
    chk_vec("rst:sum", sum_o, '0);
    chk_bit("rst:ovf", ovf_o, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // Simple add: 5 + 2*3 = 11
    a = N'(5); b = N'(3); e = N'(11);
    run_op("simple", a, b, e, 1'b0, 1'b1);

    // Carry across the first chunk boundary: (2^64-1) + 2 = 2^64 + 1
    a = '0; a[63:0] = '1; b = N'(1);
    e = '0; e[64] = 1'b1; e[0] = 1'b1;
    run_op("chunk_carry", a, b, e, 1'b0, 1'b1);

    // Full-width wrap through the adder
    a = '1; b = N'(1); e = N'(1);
    run_op("wrap_add", a, b, e, 1'b1, 1'b1);

    // Wrap caused only by the shifted-out top carry bit
    a = '0; b = '0; b[N-1] = 1'b1; e = '0;
    run_op("wrap_shout", a, b, e, 1'b1, 1'b1);

    // Backpressure: hold the result for 20 cycles
    a = rand_vec(); b = rand_vec();
    m = ref_add(a, b);
    run_op("bp", a, b, m[N-1:0], m[N], 1'b0);
    for (int i = 0; i < 20; i++) begin
      out_ready = 1'b0;
      s_in      = rand_vec();
      in_valid  = 1'($urandom_range(0, 1));
      chk_vec("bp:sum_hold", sum_o, m[N-1:0]);
      chk_bit("bp:ovf_hold", ovf_o, m[N]);
      chk_bit("bp:in_ready_low", in_ready, 1'b0);
      chk_bit("bp:out_valid_high", out_valid, 1'b1);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_bit("bp:out_valid_after", out_valid, 1'b0);
    chk_bit("bp:in_ready_after", in_ready, 1'b1);
    prev = m[N-1:0];

    // Reset in the middle of ADD, with chunk 25 next
    in_valid = 1'b1;
    s_in     = '1;
    c_in     = '0;
    tick();
    in_valid = 1'b0;
    repeat (25) tick();
    lowmask = '0;
    lowmask[25*CHUNK-1:0] = '1;
    chk_vec("mid:upper_untouched", sum_o >> (25 * CHUNK), prev >> (25 * CHUNK));
    chk_vec("mid:lower_written", sum_o & lowmask, lowmask);
    rst_n = 1'b0;
    #1;
    chk_bit("mid_rst:in_ready", in_ready, 1'b1);
    chk_bit("mid_rst:out_valid", out_valid, 1'b0);
    chk_vec("mid_rst:sum", sum_o, '0);
    chk_bit("mid_rst:ovf", ovf_o, 1'b0);
    tick();
    chk_bit("mid_rst:out_valid_held", out_valid, 1'b0);
    rst_n = 1'b1;
    a = N'(7); b = '0; e = N'(7);
    run_op("after_rst", a, b, e, 1'b0, 1'b1);

    // Back-to-back random traffic with random backpressure
    sent  = 0;
    got   = 0;
    cyc   = 0;
    cur_s = pick_vec();
    cur_c = pick_vec();
    while (got < NRAND && cyc < 70000) begin
      in_valid = (sent < NRAND) && ($urandom_range(0, 3) != 0);
      if (in_valid) begin
        s_in = cur_s;
        c_in = cur_c;
      end else begin
        s_in = rand_vec();
        c_in = rand_vec();
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        chk_bit("rnd:no_extra_result", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          m = exp_q.pop_front();
          chk_vec("rnd:sum", sum_o, m[N-1:0]);
          chk_bit("rnd:ovf", ovf_o, m[N]);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(cur_s, cur_c));
        sent++;
        cur_s = pick_vec();
        cur_c = pick_vec();
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk_int("rnd:results_seen", got, NRAND);
    chk_int("rnd:queue_empty", exp_q.size(), 0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csa_resolve.md
CSA_RESOLVE -- requirements
Module: csa_resolve

Interface
- REQ-001 The block SHALL have parameter Size, default 3072: operand width.
- REQ-002 The block SHALL have parameter Size_bi, default 64: guard width.
- REQ-003 The block SHALL have parameter Size_log, default 8: log guard width.
- REQ-004 The block SHALL have parameter Chunk, default 64: bits resolved per cycle.
- REQ-005 The block SHALL use N = Size+Size_bi+Size_log (3144 at defaults) and NCHUNK = ceil(N/Chunk) (50 at defaults).
- REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
- REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
- REQ-008 The block SHALL have port in_valid, input, 1 bit: the s and c operands are valid.
- REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
- REQ-010 The block SHALL have port s, input, N bits: carry-save sum vector.
- REQ-011 The block SHALL have port c, input, N bits: carry-save carry vector, unshifted, with bit i weighted 2^(i+1).
- REQ-012 The block SHALL have port out_valid, output, 1 bit: the result is valid.
- REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
- REQ-014 The block SHALL have port sum, output, N bits: (s + 2*c) mod 2^N.
- REQ-015 The block SHALL have port ovf, output, 1 bit: set when s + 2*c >= 2^N.

Function
- REQ-016 The block SHALL implement the states IDLE, ADD and DONE.
- REQ-017 The block SHALL assert in_ready only in IDLE.
- REQ-018 In IDLE, when in_valid=1, the block SHALL capture s and {c[N-2:0],1'b0}, clear the chunk index and carry, and enter ADD on the next edge.
- REQ-019 The block SHALL register c[N-1] at capture as a shifted-out overflow bit.
- REQ-020 In ADD, each cycle the block SHALL add chunk k of both captured operands plus the carry register, write the Chunk-bit result into sum bits [k*Chunk +: Chunk], update the carry, and increment k.
- REQ-021 The block SHALL treat operand bits at or above N in the last chunk as zero and SHALL NOT write them to sum.
- REQ-022 After chunk NCHUNK-1, the block SHALL enter DONE.
- REQ-023 The block SHALL set ovf to (padded-sum bit N) OR (the shifted-out c[N-1]).
- REQ-024 Latency SHALL be fixed: handshake at edge E, then out_valid high from edge E+1+NCHUNK onward (51 cycles at defaults).
- REQ-025 The block SHALL assert out_valid only in DONE.
- REQ-026 The block SHALL hold sum and ovf stable while out_valid=1 and out_ready=0.
- REQ-027 In DONE, when out_ready=1, the block SHALL return to IDLE on that edge.
- REQ-028 The block SHALL allow in_ready to rise the following cycle; it SHALL NOT accept same-cycle pass-through.
- REQ-029 The block SHALL ignore in_valid and changes on s and c outside IDLE; operands SHALL be captured only at the accept edge.
- REQ-030 The block SHALL allow in_valid to be deasserted without handshake and SHALL NOT require any minimum idle gap.
- REQ-031 The block SHALL NOT change sum bits above chunk k during ADD; only out_valid qualifies sum.

Reset
- REQ-032 When rst_n is low, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, in_ready=1, out_valid=0, sum=0, ovf=0, carry=0 and k=0.
- REQ-033 On reset during ADD or DONE, the block SHALL abandon the operation and SHALL NOT issue a spurious out_valid after release.
- REQ-034 After rst_n is released, the block SHALL accept in_valid on the first rising edge.

Verification
- REQ-035 The bench SHALL check a simple add: s=5, c=3 -> sum=11, ovf=0, with out_valid exactly 51 cycles after the accept edge.
- REQ-036 The bench SHALL check carry across a chunk boundary: s=2^64-1, c=1 -> sum=2^64+1, ovf=0.
- REQ-037 The bench SHALL check full-width wrap: s=2^N-1, c=1 -> sum=1, ovf=1; and s=0, c=2^(N-1) -> sum=0, ovf=1.
- REQ-038 The bench SHALL check backpressure: out_ready held at 0 for 20 cycles -> sum and ovf stable and in_ready=0 throughout; accepted on the first out_ready=1 cycle, then in_ready=1 on the next cycle.
- REQ-039 The bench SHALL check reset mid-ADD: rst_n pulsed low at chunk 25 -> outputs zero immediately; after release, a fresh s=7, c=0 completes with sum=7.
- REQ-040 The bench SHALL check back-to-back traffic: 1000 random s and c pairs with random out_ready -> every sum and ovf matches a reference model of s + 2*c, with no lost or duplicated results.
